// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the SRAM port arbiter.
// The arbiter connects through the slave modport. The requesters (IF stage,
// MEM stage, external bus master) and the memory macro connect through the
// master modport.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // instruction fetch
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  // MEM-stage load/store
  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  // external burst master
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_len;
  logic [DW-1:0] bus_wdata;
  logic          bus_gnt;
  logic          bus_valid;
  logic [DW-1:0] bus_rdata;
  logic          bus_done;
  // pipeline hold
  logic          stall;
  // memory macro
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_rd, dm_wr, dm_addr, dm_wdata,
    input  bus_req, bus_we, bus_addr, bus_len, bus_wdata,
    input  mem_rdata,
    output if_gnt, if_valid, if_rdata,
    output dm_gnt, dm_valid, dm_rdata,
    output bus_gnt, bus_valid, bus_rdata, bus_done,
    output stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_rd, dm_wr, dm_addr, dm_wdata,
    output bus_req, bus_we, bus_addr, bus_len, bus_wdata,
    output mem_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  dm_gnt, dm_valid, dm_rdata,
    input  bus_gnt, bus_valid, bus_rdata, bus_done,
    input  stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port SRAM arbiter for instruction fetch, MEM-stage
// load/store and an external burst master.
// Priority in ARB: starved bus > dm > if > bus. A bus win issues beat 0 at
// once and, for multi-beat bursts, continues in BURST one beat per cycle.
// Grants and mem_* outputs are combinational; valids are registered and the
// rdata ports forward mem_rdata in the valid cycle.
// Optional macro DM_PREEMPT_EN: a dm request steals single cycles from an
// ongoing burst; the burst beat is held and reissued on the next cycle.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave p
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t        state_q;
  logic [SW-1:0] starve_q;
  logic [3:0]    beat_q;
  logic [3:0]    len_q;
  logic [AW-1:0] base_q;
  logic          we_q;
  logic          if_valid_q;
  logic          dm_valid_q;
  logic          bus_valid_q;

  logic          dm_req_s;
  logic          starved_s;
  logic          if_gnt_s;
  logic          dm_gnt_s;
  logic          bus_gnt_s;
  logic          bus_done_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;

  assign dm_req_s  = p.dm_rd | p.dm_wr;
  assign starved_s = (starve_q == SW'(STARVE_MAX)) & p.bus_req;

  // Pick the single winner of this cycle and route its access to the memory.
  always_comb begin
    if_gnt_s    = 1'b0;
    dm_gnt_s    = 1'b0;
    bus_gnt_s   = 1'b0;
    bus_done_s  = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {AW{1'b0}};
    mem_wdata_s = {DW{1'b0}};

    if (rst_n == 1'b0) begin
      // nothing is granted while reset is held, whatever the requests are
      bus_gnt_s = 1'b0;
    end else if (state_q == ST_BURST) begin
`ifdef DM_PREEMPT_EN
      if (dm_req_s) begin
        dm_gnt_s = 1'b1;
      end else begin
        bus_gnt_s = 1'b1;
      end
`else
      bus_gnt_s = 1'b1;
`endif
    end else begin
      if (starved_s) begin
        bus_gnt_s = 1'b1;
      end else if (dm_req_s) begin
        dm_gnt_s = 1'b1;
      end else if (p.if_req) begin
        if_gnt_s = 1'b1;
      end else if (p.bus_req) begin
        bus_gnt_s = 1'b1;
      end else begin
        bus_gnt_s = 1'b0;
      end
    end

    if (dm_gnt_s) begin
      // rd and wr together is resolved as a write
      mem_addr_s  = p.dm_addr;
      mem_we_s    = p.dm_wr;
      mem_wdata_s = p.dm_wdata;
    end else if (if_gnt_s) begin
      mem_addr_s = p.if_addr;
    end else if (bus_gnt_s) begin
      mem_wdata_s = p.bus_wdata;
      if (state_q == ST_BURST) begin
        mem_addr_s = base_q + AW'(beat_q);
        mem_we_s   = we_q;
        bus_done_s = (beat_q == len_q);
      end else begin
        mem_addr_s = p.bus_addr;
        mem_we_s   = p.bus_we;
        bus_done_s = (p.bus_len == 4'd0);
      end
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Arbitration FSM, starvation counter, burst bookkeeping and read-valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      starve_q    <= {SW{1'b0}};
      beat_q      <= 4'd0;
      len_q       <= 4'd0;
      base_q      <= {AW{1'b0}};
      we_q        <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      bus_valid_q <= 1'b0;
    end else begin
      if_valid_q  <= if_gnt_s;
      dm_valid_q  <= dm_gnt_s & ~p.dm_wr;
      bus_valid_q <= bus_gnt_s & ~mem_we_s;

      case (state_q)
        ST_ARB: begin
          if (bus_gnt_s) begin
            base_q   <= p.bus_addr;
            len_q    <= p.bus_len;
            we_q     <= p.bus_we;
            starve_q <= {SW{1'b0}};
            if (p.bus_len != 4'd0) begin
              state_q <= ST_BURST;
              beat_q  <= 4'd1;
            end else begin
              state_q <= ST_ARB;
              beat_q  <= 4'd0;
            end
          end else if (p.bus_req) begin
            if (starve_q != SW'(STARVE_MAX)) begin
              starve_q <= starve_q + SW'(1);
            end else begin
              starve_q <= starve_q;
            end
          end else begin
            starve_q <= {SW{1'b0}};
          end
        end
        ST_BURST: begin
          // bus_req is not looked at until the burst is over
          starve_q <= {SW{1'b0}};
          if (bus_gnt_s) begin
            if (beat_q == len_q) begin
              state_q <= ST_ARB;
              beat_q  <= 4'd0;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end else begin
            // preempted cycle: the pending beat is reissued next cycle
            beat_q <= beat_q;
          end
        end
        default: begin
          state_q <= ST_ARB;
        end
      endcase
    end
  end

  assign p.if_gnt    = if_gnt_s;
  assign p.dm_gnt    = dm_gnt_s;
  assign p.bus_gnt   = bus_gnt_s;
  assign p.bus_done  = bus_done_s;
  assign p.mem_en    = if_gnt_s | dm_gnt_s | bus_gnt_s;
  assign p.mem_we    = mem_we_s;
  assign p.mem_addr  = mem_addr_s;
  assign p.mem_wdata = mem_wdata_s;
  assign p.stall     = rst_n & ((p.if_req & ~if_gnt_s) | (dm_req_s & ~dm_gnt_s));

  assign p.if_valid  = if_valid_q;
  assign p.dm_valid  = dm_valid_q;
  assign p.bus_valid = bus_valid_q;
  assign p.if_rdata  = if_valid_q  ? p.mem_rdata : {DW{1'b0}};
  assign p.dm_rdata  = dm_valid_q  ? p.mem_rdata : {DW{1'b0}};
  assign p.bus_rdata = bus_valid_q ? p.mem_rdata : {DW{1'b0}};

endmodule
